egress_shaper: RTL and testbench

EGRESS_SHAPER -- requirements
Module: egress_shaper

---
 rtl/egress_shaper.sv | 127 ++++++++++++
 tb/tb_egress_shaper.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/egress_shaper.sv
// Egress shaper: a FIFO that absorbs one switch output lane, a one-word output register,
// and a token-bucket rate limiter that gates moving words from the FIFO to the output register.
module egress_shaper #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TOKEN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  input  logic                     cfg_enable,
  input  logic [15:0]              cfg_period,
  input  logic [TOKEN_WIDTH-1:0]   cfg_burst,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     almost_full,
  output logic [15:0]              drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] OccFull = (AW+1)'(DEPTH);
  localparam logic [AW:0] OccAlmostFull = (AW+1)'(DEPTH - 2);

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            occ_q, occ_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [15:0]            drop_q, drop_d;
  logic [15:0]            refill_q, refill_d;
  logic [TOKEN_WIDTH-1:0] tokens_q, tokens_d;

  logic                   fifo_empty, fifo_full;
  logic                   push, load, xfer, tick;
  logic [15:0]            period_last;
  logic [TOKEN_WIDTH-1:0] tok;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OccFull);
  // A full FIFO drops the incoming word even if a pop frees a slot at the same edge.
  assign push = in_valid && !fifo_full;
  assign xfer = out_valid_q && out_ready;
  assign load = !fifo_empty && (!out_valid_q || out_ready) &&
                (!cfg_enable || (tokens_q != '0));

  assign period_last = (cfg_period == 16'd0) ? 16'd0 : cfg_period - 16'd1;
  // ">=" so a period shortened below the running count still wraps promptly.
  assign tick = cfg_enable && (refill_q >= period_last);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    drop_d      = drop_q;
    refill_d    = refill_q;
    tokens_d    = tokens_q;
    tok         = tokens_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (load) rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !load) begin
      occ_d = occ_q + (AW+1)'(1);
    end else if (!push && load) begin
      occ_d = occ_q - (AW+1)'(1);
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    if (in_valid && fifo_full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    if (!cfg_enable) begin
      refill_d = 16'd0;
    end else begin
      refill_d = tick ? 16'd0 : refill_q + 16'd1;
      if (tick && (tok < cfg_burst)) tok = tok + TOKEN_WIDTH'(1);
      if (load) tok = tok - TOKEN_WIDTH'(1);
      if (tok > cfg_burst) tok = cfg_burst;
      tokens_d = tok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drop_q      <= 16'd0;
      refill_q    <= 16'd0;
      tokens_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_q      <= drop_d;
      refill_q    <= refill_d;
      tokens_q    <= tokens_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign occupancy   = occ_q;
  assign almost_full = (occ_q >= OccAlmostFull);
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_egress_shaper.sv
// Scoreboard bench for egress_shaper: stimulus queues expected words, a monitor pops and
// compares on each output transfer and checks hold stability during stalls.
module tb_egress_shaper;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        cfg_enable;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_burst;
  logic [4:0]  occupancy;
  logic        almost_full;
  logic [15:0] drop_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  int          ts_q[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  egress_shaper #(.DATA_WIDTH(64), .DEPTH(16), .TOKEN_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .cfg_enable  (cfg_enable),
    .cfg_period  (cfg_period),
    .cfg_burst   (cfg_burst),
    .occupancy   (occupancy),
    .almost_full (almost_full),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, well away from the active edge.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 64'(out_valid), 64'd1);
        chk("stall_data_hold", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        ts_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_data, 64'hDEAD_BEEF);
        end else begin
          chk("out_data_order", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_word(input logic [63:0] d, input bit accepted);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    if (accepted) exp_q.push_back(d);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    cfg_enable = 1'b0;
    cfg_period = 16'd4;
    cfg_burst  = 8'd2;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_almost_full", 64'(almost_full), 64'd0);

    // Unshaped 3-word burst: 2-edge latency, then one word per cycle.
    ts_q.delete();
    drive_word(64'h11, 1'b1);
    base = cyc;
    drive_word(64'h22, 1'b1);
    drive_word(64'h33, 1'b1);
    idle();
    repeat (6) @(negedge clk);
    chk("burst3_count", 64'(ts_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < ts_q.size(); i++)
      chk("burst3_timing", 64'(ts_q[i]), 64'(base + 2 + i));

    // 10-word stream with out_ready toggling every cycle.
    for (int i = 0; i < 10; i++) begin
      drive_word(64'hA0 + 64'(i), 1'b1);
      out_ready = (i % 2 == 0);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = ~out_ready;
    end
    drain("toggle_drain");

    // Fill with out_ready low: word 0 parks in the output register, 16 queue, 3 drop.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_word(64'h100 + 64'(i), i <= 16);
    idle();
    chk("full_occupancy", 64'(occupancy), 64'd16);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_out_data", out_data, 64'h100);
    chk("full_drop_count", 64'(drop_count), 64'd3);
    chk("full_almost_full", 64'(almost_full), 64'd1);
    // Push into a full FIFO while a pop happens: still dropped.
    drive_word(64'hEE, 1'b0);
    out_ready = 1'b1;
    idle();
    chk("pushpop_full_occupancy", 64'(occupancy), 64'd15);
    chk("pushpop_full_drop", 64'(drop_count), 64'd4);
    drain("full_drain");
    chk("empty_almost_full", 64'(almost_full), 64'd0);

    // Mid-traffic reset discards queued words; in_valid during reset is ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_word(64'h500 + 64'(i), 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h99;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_occupancy", 64'(occupancy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_drop_count", 64'(drop_count), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_still_empty", 64'(out_valid), 64'd0);
    ts_q.delete();
    drive_word(64'hAB, 1'b1);
    base = cyc;
    idle();
    repeat (4) @(negedge clk);
    chk("postrst_count", 64'(ts_q.size()), 64'd1);
    if (ts_q.size() > 0) chk("postrst_latency", 64'(ts_q[0]), 64'(base + 2));

    // Shaped: period 4, burst 2, tokens 0. Ticks at edges 4,8,12,... after enabling;
    // bucket full after edge 8, words sampled at edges 9..14, loads at 10,11,13,17,21,25.
    ts_q.delete();
    @(negedge clk);
    cfg_enable = 1'b1;
    base = cyc;
    repeat (7) @(negedge clk);
    for (int i = 0; i < 6; i++) drive_word(64'hC0 + 64'(i), 1'b1);
    idle();
    while (cyc < base + 30) @(negedge clk);
    chk("shaped_count", 64'(ts_q.size()), 64'd6);
    begin
      int exp_ts[6] = '{10, 11, 13, 17, 21, 25};
      for (int i = 0; i < 6 && i < ts_q.size(); i++)
        chk("shaped_timing", 64'(ts_q[i] - base), 64'(exp_ts[i]));
    end
    drain("shaped_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
